stock_word_packer: RTL and testbench

- Upstream feeder for the trend/action evaluator: accepts raw daily price samples over a valid/ready handshake, quantizes each to 5 bits, collects three consecutive days, and packs them with the ownership bit into the 16-bit stock word.
- Holds each packed word stable for one full evaluator frame.
- Tracks ownership from the evaluator's 16-bit action code, which is fed back to this block.

---
 rtl/stock_word_packer_pkg.sv | 53 +++++
 rtl/stock_word_packer_if.sv | 24 ++
 rtl/stock_word_packer_price_quantizer.sv | 28 ++
 rtl/stock_word_packer.sv | 129 ++++++++++++
 tb/tb_stock_word_packer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/stock_word_packer_pkg.sv
// Shared types, action codes and stock-word field layout for the packer and the evaluator.
package stock_word_packer_pkg;

  typedef enum logic [1:0] {
    COLLECT0 = 2'd0,
    COLLECT1 = 2'd1,
    COLLECT2 = 2'd2,
    HOLD     = 2'd3
  } pack_state_t;

  localparam logic [15:0] ACT_FAIL     = 16'd0;
  localparam logic [15:0] ACT_SELL     = 16'd1;
  localparam logic [15:0] ACT_STAY_OUT = 16'd2;
  localparam logic [15:0] ACT_BUY      = 16'd3;
  localparam logic [15:0] ACT_BUY_MORE = 16'd4;
  localparam logic [15:0] ACT_WAIT     = 16'd5;
  localparam logic [15:0] ACT_BUY_DIP  = 16'd6;
  localparam logic [15:0] ACT_KEEP     = 16'd7;
  localparam logic [15:0] ACT_HOLD     = 16'd8;

  localparam int DAY_W     = 5;
  localparam int OWNED_BIT = 15;
  localparam int DAY1_MSB  = 14;
  localparam int DAY1_LSB  = 10;
  localparam int DAY2_MSB  = 9;
  localparam int DAY2_LSB  = 5;
  localparam int DAY3_MSB  = 4;
  localparam int DAY3_LSB  = 0;

  // Sell clears ownership, any buy/keep flavour sets it, everything else leaves it alone.
  function automatic logic owned_next(input logic cur, input logic [15:0] code);
    case (code)
      ACT_SELL:                                    return 1'b0;
      ACT_BUY, ACT_BUY_MORE, ACT_BUY_DIP, ACT_KEEP: return 1'b1;
      ACT_FAIL, ACT_STAY_OUT, ACT_WAIT, ACT_HOLD:  return cur;
      default:                                     return cur;
    endcase
  endfunction

  function automatic logic [15:0] pack_word(input logic own,
                                            input logic [DAY_W-1:0] d1,
                                            input logic [DAY_W-1:0] d2,
                                            input logic [DAY_W-1:0] d3);
    logic [15:0] w;
    w                     = '0;
    w[OWNED_BIT]          = own;
    w[DAY1_MSB:DAY1_LSB]  = d1;
    w[DAY2_MSB:DAY2_LSB]  = d2;
    w[DAY3_MSB:DAY3_LSB]  = d3;
    return w;
  endfunction

endpackage

// File: rtl/stock_word_packer_if.sv
// Price/action inputs and packed-word outputs of the stock word packer.
interface stock_word_packer_if #(
  parameter int PRICE_W = 16
);
  logic               price_valid;
  logic [PRICE_W-1:0] price_in;
  logic               price_ready;
  logic               action_valid;
  logic [15:0]        action_code;
  logic [15:0]        stock_out;
  logic               word_valid;
  logic               frame_start;
  logic               owned;

  modport master (
    output price_valid, price_in, action_valid, action_code,
    input  price_ready, stock_out, word_valid, frame_start, owned
  );

  modport slave (
    input  price_valid, price_in, action_valid, action_code,
    output price_ready, stock_out, word_valid, frame_start, owned
  );
endinterface

// File: rtl/stock_word_packer_price_quantizer.sv
// Combinational price quantizer: subtract floor, shift down, saturate to a 5-bit day field.
module stock_word_packer_price_quantizer #(
  parameter int PRICE_W    = 16,
  parameter int PRICE_BASE = 0,
  parameter int Q_SHIFT    = 11
) (
  input  logic [PRICE_W-1:0] i_price,
  output logic [4:0]         o_q
);

  localparam logic [PRICE_W-1:0] BASE = PRICE_W'(PRICE_BASE);

  function automatic logic [4:0] sat5(input logic [PRICE_W-1:0] v);
    if (v > PRICE_W'(31)) return 5'd31;
    else                  return v[4:0];
  endfunction

  logic [PRICE_W-1:0] w_diff;
  logic [PRICE_W-1:0] w_shift;

  always_comb begin
    w_diff  = i_price - BASE;
    w_shift = w_diff >> Q_SHIFT;
    // Prices below the floor would wrap in the subtraction, so clamp them to zero.
    o_q     = (i_price < BASE) ? 5'd0 : sat5(w_shift);
  end

endmodule

// File: rtl/stock_word_packer.sv
// Collects three quantized daily prices plus ownership into a 16-bit stock word held for one frame.
// Optional PACKER_SLIDING_WINDOW_EN: after the first frame each new sample shifts the window and packs a word.
module stock_word_packer
  import stock_word_packer_pkg::*;
#(
  parameter int PRICE_W     = 16,
  parameter int PRICE_BASE  = 0,
  parameter int Q_SHIFT     = 11,
  parameter int HOLD_CYCLES = 6
) (
  input  logic             clk,
  input  logic             rst,
  stock_word_packer_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  pack_state_t  r_state;
  logic [4:0]   r_day1;
  logic [4:0]   r_day2;
  logic [15:0]  r_stock;
  logic         r_word_valid;
  logic         r_frame_start;
  logic         r_owned;
  logic         r_ready;
  logic [CNT_W-1:0] r_cnt;
`ifdef PACKER_SLIDING_WINDOW_EN
  logic [4:0]   r_day3;
  logic         r_filled;
`endif

  logic [4:0]   w_q;
  logic         w_xfer;

  stock_word_packer_price_quantizer #(
    .PRICE_W   (PRICE_W),
    .PRICE_BASE(PRICE_BASE),
    .Q_SHIFT   (Q_SHIFT)
  ) u_quant (
    .i_price(bus.price_in),
    .o_q    (w_q)
  );

  assign w_xfer = bus.price_valid && r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= COLLECT0;
      r_day1        <= '0;
      r_day2        <= '0;
      r_stock       <= '0;
      r_word_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_owned       <= 1'b0;
      r_ready       <= 1'b0;
      r_cnt         <= '0;
`ifdef PACKER_SLIDING_WINDOW_EN
      r_day3        <= '0;
      r_filled      <= 1'b0;
`endif
    end else begin
      // Packing below reads the pre-update r_owned, so a same-edge action lands in the next word.
      if (bus.action_valid) r_owned <= owned_next(r_owned, bus.action_code);

      case (r_state)
        COLLECT0: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_day1  <= w_q;
            r_state <= COLLECT1;
          end
        end
        COLLECT1: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_day2  <= w_q;
            r_state <= COLLECT2;
          end
        end
        COLLECT2: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
`ifdef PACKER_SLIDING_WINDOW_EN
            if (r_filled) begin
              r_day1  <= r_day2;
              r_day2  <= r_day3;
              r_stock <= pack_word(r_owned, r_day2, r_day3, w_q);
            end else begin
              r_stock <= pack_word(r_owned, r_day1, r_day2, w_q);
            end
            r_day3   <= w_q;
            r_filled <= 1'b1;
`else
            r_stock <= pack_word(r_owned, r_day1, r_day2, w_q);
`endif
            r_word_valid  <= 1'b1;
            r_frame_start <= 1'b1;
            r_cnt         <= '0;
            r_ready       <= 1'b0;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          r_frame_start <= 1'b0;
          if (r_cnt == CNT_LAST) begin
            r_word_valid <= 1'b0;
            r_ready      <= 1'b1;
`ifdef PACKER_SLIDING_WINDOW_EN
            r_state      <= COLLECT2;
`else
            r_state      <= COLLECT0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= COLLECT0;
      endcase
    end
  end

  assign bus.price_ready = r_ready;
  assign bus.stock_out   = r_stock;
  assign bus.word_valid  = r_word_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.owned       = r_owned;

endmodule

// File: tb/tb_stock_word_packer.sv
// Randomized and directed bench for stock_word_packer; two instances (floor 0 and floor 0x0800) share stimulus.
module tb_stock_word_packer;

  localparam int HOLD   = 6;
  localparam int BASE_A = 0;
  localparam int BASE_B = 'h0800;
`ifdef PACKER_SLIDING_WINDOW_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stock_word_packer_if #(.PRICE_W(16)) ifa ();
  stock_word_packer_if #(.PRICE_W(16)) ifb ();

  stock_word_packer #(.PRICE_W(16), .PRICE_BASE(BASE_A), .Q_SHIFT(11), .HOLD_CYCLES(HOLD))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  stock_word_packer #(.PRICE_W(16), .PRICE_BASE(BASE_B), .Q_SHIFT(11), .HOLD_CYCLES(HOLD))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: sample windows, ownership, remaining hold cycles.
  int          win [2][$];
  int          bases [2] = '{BASE_A, BASE_B};
  bit          m_own;
  logic [15:0] m_word [2];
  int          m_hold;
  bit          m_frame;
  bit          m_ready;

  function automatic int quant(input int p, input int base);
    int q;
    if (p < base) return 0;
    q = (p - base) / 2048;
    return (q > 31) ? 31 : q;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      win[d].delete();
      m_word[d] = 16'h0000;
    end
    m_own = 0; m_hold = 0; m_frame = 0; m_ready = 0;
  endtask

  task automatic m_edge(input bit xfer, input int p, input bit av, input int ac);
    bit own_before;
    own_before = m_own;
    if (av) begin
      if (ac == 1) m_own = 0;
      else if (ac == 3 || ac == 4 || ac == 6 || ac == 7) m_own = 1;
    end
    m_frame = 0;
    if (m_hold > 0) m_hold--;
    if (xfer) begin
      for (int d = 0; d < 2; d++) begin
        win[d].push_back(quant(p, bases[d]));
        if (SLIDE && win[d].size() > 3) void'(win[d].pop_front());
      end
      if (win[0].size() == 3) begin
        for (int d = 0; d < 2; d++) begin
          m_word[d] = 16'((int'(own_before) << 15) | (win[d][0] << 10) | (win[d][1] << 5) | win[d][2]);
          if (!SLIDE) win[d].delete();
        end
        m_hold  = HOLD;
        m_frame = 1;
      end
    end
    m_ready = (m_hold == 0);
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_a_ready"}, 16'(ifa.price_ready), 16'(m_ready));
    chk({pfx, "_a_wvalid"}, 16'(ifa.word_valid), 16'(m_hold > 0));
    chk({pfx, "_a_fstart"}, 16'(ifa.frame_start), 16'(m_frame));
    chk({pfx, "_a_owned"}, 16'(ifa.owned), 16'(m_own));
    chk({pfx, "_a_word"}, ifa.stock_out, m_word[0]);
    chk({pfx, "_b_ready"}, 16'(ifb.price_ready), 16'(m_ready));
    chk({pfx, "_b_wvalid"}, 16'(ifb.word_valid), 16'(m_hold > 0));
    chk({pfx, "_b_owned"}, 16'(ifb.owned), 16'(m_own));
    chk({pfx, "_b_word"}, ifb.stock_out, m_word[1]);
  endtask

  task automatic step(input bit v, input logic [15:0] p, input bit av, input logic [15:0] ac,
                      output bit xfer);
    @(negedge clk);
    ifa.price_valid = v;  ifb.price_valid = v;
    ifa.price_in = p;     ifb.price_in = p;
    ifa.action_valid = av; ifb.action_valid = av;
    ifa.action_code = ac;  ifb.action_code = ac;
    xfer = v && m_ready;
    @(posedge clk);
    #1;
    m_edge(xfer, int'(p), av, int'(ac));
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) step(0, 16'h0000, 0, 16'h0000, x);
  endtask

  task automatic act(input logic [15:0] code);
    bit x;
    step(0, 16'h0000, 1, code, x);
  endtask

  task automatic send(input logic [15:0] p);
    bit x;
    for (int i = 0; i < 20; i++) begin
      step(1, p, 0, 16'h0000, x);
      if (x) return;
    end
    chk("send_timeout", 16'h0000, 16'h0001);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (m_ready) return;
      idle(1);
    end
    chk("ready_timeout", 16'(m_ready), 16'h0001);
  endtask

  // Called just after a sampling point; asserts reset between clock edges.
  task automatic do_reset(input string pfx);
    #1 rst = 1'b1;
    m_reset();
    #1 check_all({pfx, "_async"});
    @(posedge clk);
    #1 check_all({pfx, "_held"});
    #1 rst = 1'b0;
  endtask

  initial begin
    bit x;
    int nx, k, cnt_v, cnt_f;
    ifa.price_valid = 0; ifb.price_valid = 0;
    ifa.price_in = '0;   ifb.price_in = '0;
    ifa.action_valid = 0; ifb.action_valid = 0;
    ifa.action_code = '0; ifb.action_code = '0;

    do_reset("init");
    idle(1);

    // Basic triple: days 2,4,6 with owned=0.
    send(16'h1000); send(16'h2000); send(16'h3000);
    chk("dir_word", ifa.stock_out, 16'h0886);
    cnt_v = 1; cnt_f = 1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      cnt_v += int'(ifa.word_valid);
      cnt_f += int'(ifa.frame_start);
    end
    chk("hold_len", 16'(cnt_v), 16'(HOLD));
    chk("fstart_len", 16'(cnt_f), 16'h0001);

    // Underflow below the floor and saturation at the top.
    wait_ready();
    send(16'h0400); send(16'hFFFF); send(16'h0800);
    chk("sat_word_a", ifa.stock_out, 16'h03E1);
    chk("underflow_b", 16'(ifb.stock_out[14:10]), 16'h0000);

    // Ownership through action codes.
    wait_ready();
    act(16'd4);
    send(16'h0800); send(16'h0800); send(16'h0800);
    chk("own_set", 16'(ifa.stock_out[15]), 16'h0001);
    act(16'd5);
    chk("own_keep", 16'(ifa.owned), 16'h0001);
    act(16'd1);
    wait_ready();
    send(16'h0800); send(16'h0800); send(16'h0800);
    chk("own_clr", 16'(ifa.stock_out[15]), 16'h0000);

    // Continuous valid with an incrementing source.
    wait_ready();
    nx = 0; k = 1;
    for (int i = 0; i < 27; i++) begin
      step(1, 16'(k * 'h0800), 0, 16'h0000, x);
      if (x) begin nx++; k++; end
    end
    chk("bp_xfers", 16'(nx), SLIDE ? 16'd4 : 16'd9);

    // Reset during a held word, then after two accepted samples.
    wait_ready();
    act(16'd3);
    send(16'h2000); send(16'h2000); send(16'h2000);
    idle(2);
    do_reset("rst_hold");
    idle(1);
    send(16'h7800); send(16'h7800);
    do_reset("rst_part");
    idle(1);
    send(16'h0800); send(16'h1000); send(16'h1800);
    chk("post_rst_word", ifa.stock_out, 16'h0443);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] p;
      p = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(bit'($urandom_range(0, 1)), p, ($urandom_range(0, 3) == 0),
           16'($urandom_range(0, 10)), x);
    end

`ifdef PACKER_SLIDING_WINDOW_EN
    idle(1);
    do_reset("rst_slide");
    idle(1);
    send(16'h0800); send(16'h1000); send(16'h1800);
    chk("slide_w1", ifa.stock_out, 16'h0443);
    send(16'h2000);
    chk("slide_w2", ifa.stock_out, 16'h0864);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
